// File: rtl/pe_dot_scoreboard.sv
// pe_dot_scoreboard: checks per-channel dot-product results from a DUT LATENCY cycles after
// their operands, tracking pass/fail status, saturating counters and the first mismatch.
module pe_dot_scoreboard #(
   parameter int NUM_CH        = 4,
   parameter int DOT_SIZE      = 8,
   parameter int FEATURE_WIDTH = 8,
   parameter int FILTER_WIDTH  = 8,
   parameter int OUT_WIDTH     = 20,
   parameter int LATENCY       = 4,
   parameter int SIGN_MODE     = 0,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                                      clock,
   input  logic                                      resetn,
   input  logic                                      i_enable,
   input  logic                                      i_clear,
   input  logic                                      i_valid,
   input  logic [NUM_CH*DOT_SIZE*FEATURE_WIDTH-1:0]  i_feature,
   input  logic [NUM_CH*DOT_SIZE*FILTER_WIDTH-1:0]   i_filter,
   input  logic [NUM_CH*OUT_WIDTH-1:0]               i_result,
   output logic [1:0]                                o_status,
   output logic [CNT_WIDTH-1:0]                      o_err_count,
   output logic [CNT_WIDTH-1:0]                      o_check_count,
   output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] o_first_err_ch,
   output logic [OUT_WIDTH-1:0]                      o_first_err_exp,
   output logic [OUT_WIDTH-1:0]                      o_first_err_act
);
   localparam int PW = FEATURE_WIDTH + FILTER_WIDTH + $clog2(DOT_SIZE + 1);
   localparam int AW = PW > OUT_WIDTH ? PW : OUT_WIDTH;
   localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
   localparam int NW = $clog2(NUM_CH + 1);
   localparam int EW = CNT_WIDTH + NW;

   typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, FAIL = 2'd2} state_t;

   state_t                          state;
   logic [LATENCY-1:0]              dv;
   logic [NUM_CH*OUT_WIDTH-1:0]     dexp [LATENCY];
   logic [NUM_CH*OUT_WIDTH-1:0]     exp_in;
   logic [NUM_CH*OUT_WIDTH-1:0]     exp_out;
   logic [FEATURE_WIDTH-1:0]        f;
   logic [FILTER_WIDTH-1:0]         g;
   logic signed [FEATURE_WIDTH-1:0] fd;
   logic signed [FILTER_WIDTH-1:0]  gd;
   logic signed [AW-1:0]            fe, ge, acc;
   logic                            chk;
   logic [NW-1:0]                   nerr;
   logic [CW-1:0]                   fch;
   logic [OUT_WIDTH-1:0]            fexp, fact;
   logic [EW-1:0]                   err_sum;
   logic [CNT_WIDTH-1:0]            err_next;

   // Expected values are formed at capture time so only OUT_WIDTH bits per channel travel down the line.
   always_comb begin
      exp_in = '0;
      f = '0;
      g = '0;
      fd = '0;
      gd = '0;
      fe = '0;
      ge = '0;
      acc = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         acc = '0;
         for (int k = 0; k < DOT_SIZE; k++) begin
            f = i_feature[(c*DOT_SIZE+k)*FEATURE_WIDTH +: FEATURE_WIDTH];
            g = i_filter[(c*DOT_SIZE+k)*FILTER_WIDTH +: FILTER_WIDTH];
            fd = SIGN_MODE != 0 ? f : (f[FEATURE_WIDTH-1] ? -{1'b0, f[FEATURE_WIDTH-2:0]} : {1'b0, f[FEATURE_WIDTH-2:0]});
            gd = SIGN_MODE != 0 ? g : (g[FILTER_WIDTH-1] ? -{1'b0, g[FILTER_WIDTH-2:0]} : {1'b0, g[FILTER_WIDTH-2:0]});
            fe = fd;
            ge = gd;
            acc = acc + fe * ge;
         end
         exp_in[c*OUT_WIDTH +: OUT_WIDTH] = acc[OUT_WIDTH-1:0];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dv <= '0;
      end else begin
         dv[0] <= i_valid && i_enable;
         for (int i = 1; i < LATENCY; i++) dv[i] <= dv[i-1];
      end
   end

   always_ff @(posedge clock) begin
      dexp[0] <= exp_in;
      for (int i = 1; i < LATENCY; i++) dexp[i] <= dexp[i-1];
   end

   assign chk     = dv[LATENCY-1];
   assign exp_out = dexp[LATENCY-1];

   // Descending scan so the lowest mismatching channel is the one left in fch.
   always_comb begin
      nerr = '0;
      fch  = '0;
      fexp = '0;
      fact = '0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (chk && exp_out[c*OUT_WIDTH +: OUT_WIDTH] != i_result[c*OUT_WIDTH +: OUT_WIDTH]) begin
            nerr = nerr + NW'(1);
            fch  = CW'(c);
            fexp = exp_out[c*OUT_WIDTH +: OUT_WIDTH];
            fact = i_result[c*OUT_WIDTH +: OUT_WIDTH];
         end
      end
      err_sum  = EW'(o_err_count) + EW'(nerr);
      err_next = |err_sum[EW-1:CNT_WIDTH] ? '1 : err_sum[CNT_WIDTH-1:0];
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state           <= IDLE;
         o_err_count     <= '0;
         o_check_count   <= '0;
         o_first_err_ch  <= '0;
         o_first_err_exp <= '0;
         o_first_err_act <= '0;
      end else if (i_clear) begin
         state           <= IDLE;
         o_err_count     <= '0;
         o_check_count   <= '0;
         o_first_err_ch  <= '0;
         o_first_err_exp <= '0;
         o_first_err_act <= '0;
      end else if (chk) begin
         o_check_count <= o_check_count + CNT_WIDTH'(~&o_check_count);
         o_err_count   <= err_next;
         if (nerr != '0 && state != FAIL) begin
            state           <= FAIL;
            o_first_err_ch  <= fch;
            o_first_err_exp <= fexp;
            o_first_err_act <= fact;
         end else if (nerr == '0 && state == IDLE) begin
            state <= PASS;
         end
      end
   end

   assign o_status = state;
endmodule

// File: tb/tb_pe_dot_scoreboard.sv
// tb_pe_dot_scoreboard: two scoreboards (sign-magnitude with 4-bit counters, two's complement
// with 16-bit counters) checked every cycle against an arithmetic model plus literal expectations.
module tb_pe_dot_scoreboard;
   logic        clock = 0, resetn = 0, enable = 0, clear = 0, valid = 0;
   logic [31:0] feature = '0, filter = '0;
   logic [39:0] r0 = '0, r1 = '0;
   logic [1:0]  st0, st1;
   logic [3:0]  ec0, cc0;
   logic [15:0] ec1, cc1;
   logic        fc0, fc1;
   logic [19:0] fe0, fa0, fe1, fa1;
   int compared = 0, mismatched = 0;

   typedef struct packed {logic v; logic [31:0] f; logic [31:0] g;} beat_t;
   beat_t q[$];
   int m_st[2], m_ck[2], m_er[2], m_fc[2], m_fe[2], m_fa[2];

   localparam logic [31:0] FA = {8'h04, 8'h03, 8'h04, 8'h03};
   localparam logic [31:0] FB = {8'h82, 8'h05, 8'h82, 8'h05};
   localparam logic [39:0] R77 = {20'd7, 20'd7};
   localparam logic [39:0] R87 = {20'd8, 20'd7};
   localparam logic [39:0] R07 = {20'd0, 20'd7};

   always #5 clock = ~clock;

   pe_dot_scoreboard #(.NUM_CH(2), .DOT_SIZE(2), .FEATURE_WIDTH(8), .FILTER_WIDTH(8), .OUT_WIDTH(20),
      .LATENCY(3), .SIGN_MODE(0), .CNT_WIDTH(4)) dut0 (
      .clock(clock), .resetn(resetn), .i_enable(enable), .i_clear(clear), .i_valid(valid),
      .i_feature(feature), .i_filter(filter), .i_result(r0), .o_status(st0), .o_err_count(ec0),
      .o_check_count(cc0), .o_first_err_ch(fc0), .o_first_err_exp(fe0), .o_first_err_act(fa0));

   pe_dot_scoreboard #(.NUM_CH(2), .DOT_SIZE(2), .FEATURE_WIDTH(8), .FILTER_WIDTH(8), .OUT_WIDTH(20),
      .LATENCY(3), .SIGN_MODE(1), .CNT_WIDTH(16)) dut1 (
      .clock(clock), .resetn(resetn), .i_enable(enable), .i_clear(clear), .i_valid(valid),
      .i_feature(feature), .i_filter(filter), .i_result(r1), .o_status(st1), .o_err_count(ec1),
      .o_check_count(cc1), .o_first_err_ch(fc1), .o_first_err_exp(fe1), .o_first_err_act(fa1));

   function automatic int dec(int m, logic [7:0] x);
      return m != 0 ? int'($signed(x)) : (x[7] ? -int'(x[6:0]) : int'(x[6:0]));
   endfunction

   function automatic int dotv(int m, int c, logic [31:0] f, logic [31:0] g);
      int s = 0;
      for (int k = 0; k < 2; k++) s += dec(m, f[(c*2+k)*8 +: 8]) * dec(m, g[(c*2+k)*8 +: 8]);
      return s & 32'hFFFFF;
   endfunction

   task automatic check(string name, int act, int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a beat accepted at cycle t is judged against the result present at t+3.
   always @(posedge clock) begin
      beat_t b;
      int n, first, e, a, mx;
      if (!resetn) begin
         for (int m = 0; m < 2; m++) begin
            m_st[m] = 0; m_ck[m] = 0; m_er[m] = 0; m_fc[m] = 0; m_fe[m] = 0; m_fa[m] = 0;
         end
         q = {};
         repeat (3) q.push_back('0);
      end else begin
         b = q.pop_front();
         for (int m = 0; m < 2; m++) begin
            mx = m == 0 ? 15 : 65535;
            if (clear) begin
               m_st[m] = 0; m_ck[m] = 0; m_er[m] = 0; m_fc[m] = 0; m_fe[m] = 0; m_fa[m] = 0;
            end else if (b.v) begin
               n = 0;
               first = -1;
               for (int c = 0; c < 2; c++) begin
                  e = dotv(m, c, b.f, b.g);
                  a = m == 0 ? int'(r0[c*20 +: 20]) : int'(r1[c*20 +: 20]);
                  if (e != a) begin
                     n++;
                     if (first < 0) begin first = c; m_fe[m] = m_st[m] == 2 ? m_fe[m] : e; m_fa[m] = m_st[m] == 2 ? m_fa[m] : a; end
                  end
               end
               m_ck[m] = m_ck[m] + 1 > mx ? mx : m_ck[m] + 1;
               m_er[m] = m_er[m] + n > mx ? mx : m_er[m] + n;
               if (n > 0 && m_st[m] != 2) begin
                  m_st[m] = 2;
                  m_fc[m] = first;
               end else if (n == 0 && m_st[m] == 0) begin
                  m_st[m] = 1;
               end
            end
         end
         q.push_back({valid && enable, feature, filter});
      end
   end

   always @(negedge clock) begin
      check("d0 status", int'(st0), m_st[0]);
      check("d0 err_count", int'(ec0), m_er[0]);
      check("d0 check_count", int'(cc0), m_ck[0]);
      check("d0 first_ch", int'(fc0), m_fc[0]);
      check("d0 first_exp", int'(fe0), m_fe[0]);
      check("d0 first_act", int'(fa0), m_fa[0]);
      check("d1 status", int'(st1), m_st[1]);
      check("d1 err_count", int'(ec1), m_er[1]);
      check("d1 check_count", int'(cc1), m_ck[1]);
      check("d1 first_ch", int'(fc1), m_fc[1]);
      check("d1 first_exp", int'(fe1), m_fe[1]);
      check("d1 first_act", int'(fa1), m_fa[1]);
   end

   task automatic cyc(bit v, bit en, bit clr, logic [31:0] f, logic [31:0] g, logic [39:0] a0, logic [39:0] a1);
      @(negedge clock);
      #1;
      valid = v; enable = en; clear = clr; feature = f; filter = g; r0 = a0; r1 = a1;
   endtask

   task automatic settle();
      @(posedge clock);
      #2;
   endtask

   function automatic logic [7:0] pick();
      case ($urandom_range(0, 5))
         0: return 8'h80;
         1: return 8'h7F;
         2: return 8'hFF;
         3: return 8'h00;
         default: return 8'($urandom);
      endcase
   endfunction

   function automatic logic [19:0] res(int e);
      logic [31:0] t = e;
      return $urandom_range(0, 3) == 0 ? t[19:0] ^ (20'd1 << $urandom_range(0, 19)) : t[19:0];
   endfunction

   initial begin
      beat_t b;
      repeat (2) @(negedge clock);
      #1 resetn = 1;
      settle();
      check("reset status", int'(st0), 0);
      check("reset check_count", int'(cc0), 0);
      check("reset err_count", int'(ec0), 0);
      // clean beat, expected 3*5 + 4*(-2) = 7 on both channels
      cyc(1, 1, 0, FA, FB, '0, '0);
      cyc(0, 1, 0, '0, '0, '0, '0);
      cyc(0, 1, 0, '0, '0, '0, '0);
      cyc(0, 1, 0, '0, '0, R77, '0);
      check("latency status", int'(st0), 0);
      settle();
      check("clean status", int'(st0), 1);
      check("clean check_count", int'(cc0), 1);
      check("clean err_count", int'(ec0), 0);
      // channel 1 returns 8
      cyc(1, 1, 0, FA, FB, '0, '0);
      cyc(0, 1, 0, '0, '0, '0, '0);
      cyc(0, 1, 0, '0, '0, '0, '0);
      cyc(0, 1, 0, '0, '0, R87, '0);
      settle();
      check("mism status", int'(st0), 2);
      check("mism err_count", int'(ec0), 1);
      check("mism first_ch", int'(fc0), 1);
      check("mism first_exp", int'(fe0), 7);
      check("mism first_act", int'(fa0), 8);
      // clear collides with a mismatch check; the following beat is still in flight
      cyc(1, 1, 0, FA, FB, '0, '0);
      cyc(1, 1, 0, FA, FB, '0, '0);
      cyc(0, 1, 0, '0, '0, '0, '0);
      cyc(0, 1, 1, '0, '0, R87, '0);
      settle();
      check("clear status", int'(st0), 0);
      check("clear err_count", int'(ec0), 0);
      check("clear first_exp", int'(fe0), 0);
      cyc(0, 1, 0, '0, '0, R77, '0);
      settle();
      check("inflight status", int'(st0), 1);
      check("inflight check_count", int'(cc0), 1);
      // 20 single-channel mismatches against 4-bit counters
      for (int i = 0; i < 20; i++) cyc(1, 1, 0, FA, FB, R07, '0);
      repeat (5) cyc(0, 1, 0, '0, '0, R07, '0);
      settle();
      check("sat err_count", int'(ec0), 15);
      check("sat check_count", int'(cc0), 15);
      check("sat first_act", int'(fa0), 0);
      // reset pulse right after a valid beat
      cyc(1, 1, 0, FA, FB, '0, '0);
      @(negedge clock);
      #1 resetn = 0; valid = 0;
      #1;
      check("async status", int'(st0), 0);
      check("async err_count", int'(ec0), 0);
      check("async check_count", int'(cc0), 0);
      check("async first_ch", int'(fc0), 0);
      cyc(0, 1, 0, '0, '0, R77, '0);
      resetn = 1;
      cyc(0, 1, 0, '0, '0, R77, '0);
      settle();
      check("post-reset status t+4", int'(st0), 0);
      cyc(0, 1, 0, '0, '0, R77, '0);
      settle();
      check("post-reset check_count t+5", int'(cc0), 0);
      // two's complement: -1*2 = 0xFFFFE
      cyc(1, 1, 0, {8'h00, 8'hFF, 8'h00, 8'hFF}, {8'h00, 8'h02, 8'h00, 8'h02}, '0, '0);
      cyc(0, 1, 0, '0, '0, '0, '0);
      cyc(0, 1, 0, '0, '0, '0, '0);
      cyc(0, 1, 0, '0, '0, '0, {20'hFFFFE, 20'hFFFFE});
      settle();
      check("tc status", int'(st1), 1);
      check("tc err_count", int'(ec1), 0);
      check("tc sm mismatch status", int'(st0), 2);
      check("tc sm first_exp", int'(fe0), 20'hFFF02);
      // randomized traffic with occasional clears and resets
      for (int i = 0; i < 3000; i++) begin
         @(negedge clock);
         #1;
         resetn = $urandom_range(0, 199) != 0;
         valid  = $urandom_range(0, 3) != 0;
         enable = $urandom_range(0, 7) != 0;
         clear  = $urandom_range(0, 39) == 0;
         for (int e = 0; e < 4; e++) begin
            feature[e*8 +: 8] = pick();
            filter[e*8 +: 8]  = pick();
         end
         b = q[0];
         for (int c = 0; c < 2; c++) begin
            r0[c*20 +: 20] = res(dotv(0, c, b.f, b.g));
            r1[c*20 +: 20] = res(dotv(1, c, b.f, b.g));
         end
      end
      @(negedge clock);
      #1 resetn = 1;
      repeat (4) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/pe_dot_scoreboard.md
PE_DOT_SCOREBOARD -- requirements
Module: pe_dot_scoreboard

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning the number of independent dot-product channels checked in parallel.
REQ-002 SHALL have parameter DOT_SIZE, default 8, meaning the number of operand pairs per dot product.
REQ-003 SHALL have parameter FEATURE_WIDTH, default 8, meaning the feature element width in bits, including sign.
REQ-004 SHALL have parameter FILTER_WIDTH, default 8, meaning the filter element width in bits, including sign.
REQ-005 SHALL have parameter OUT_WIDTH, default 20, meaning the width of the DUT result under check.
REQ-006 SHALL have parameter LATENCY, default 4, range >=1, meaning the DUT cycles from operands to result.
REQ-007 SHALL have parameter SIGN_MODE, default 0, meaning 0 = sign-magnitude (MSB is sign) and 1 = two's complement.
REQ-008 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the error and check counters.
REQ-009 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-010 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-011 SHALL have port i_enable, input, 1 bit: accepts new operand beats when high.
REQ-012 SHALL have port i_clear, input, 1 bit: synchronous clear of counters and status.
REQ-013 SHALL have port i_valid, input, 1 bit: operands valid this cycle.
REQ-014 SHALL have port i_feature, input, NUM_CH*DOT_SIZE*FEATURE_WIDTH bits; element (c,k) is at [(c*DOT_SIZE+k)*FEATURE_WIDTH +: FEATURE_WIDTH].
REQ-015 SHALL have port i_filter, input, NUM_CH*DOT_SIZE*FILTER_WIDTH bits, packed the same way as i_feature.
REQ-016 SHALL have port i_result, input, NUM_CH*OUT_WIDTH bits; the channel c result is at [c*OUT_WIDTH +: OUT_WIDTH].
REQ-017 SHALL have port o_status, output, 2 bits: 0 = IDLE, 1 = PASS, 2 = FAIL.
REQ-018 SHALL have port o_err_count, output, CNT_WIDTH bits: saturating count of mismatching channel-checks.
REQ-019 SHALL have port o_check_count, output, CNT_WIDTH bits: saturating count of checked beats.
REQ-020 SHALL have port o_first_err_ch, output, $clog2(NUM_CH) bits (min 1): channel of the first mismatch.
REQ-021 SHALL have ports o_first_err_exp and o_first_err_act, both outputs, OUT_WIDTH bits each: expected and actual values at the first mismatch.

Function
REQ-022 SHALL capture the beat i_feature, i_filter into a LATENCY-deep delay line tagged with valid when i_valid && i_enable; otherwise it SHALL insert an invalid tag.
REQ-023 SHALL compare a beat presented at cycle t against i_result sampled at cycle t+LATENCY; all outputs SHALL reflect the check at t+LATENCY+1.
REQ-024 SHALL continue to check beats already in flight after i_enable falls.
REQ-025 SHALL compute the expected value per channel at full precision as sum over k of feature(c,k)*filter(c,k), decoding each operand per SIGN_MODE.
REQ-026 SHALL compute each product's sign in SIGN_MODE=0 as the XOR of the operand MSBs, with magnitude = remaining bits.
REQ-027 SHALL truncate the expected value to its OUT_WIDTH LSBs before comparing; the compare SHALL be exact bitwise.
REQ-028 SHALL increment o_check_count by 1 on each checked beat, saturating at all-ones.
REQ-029 SHALL add the number of mismatching channels in a beat to o_err_count, saturating at all-ones without wrap.
REQ-030 SHALL follow the state machine: IDLE -> PASS on a checked beat with no mismatch; IDLE or PASS -> FAIL on any mismatch; PASS stays PASS on clean beats; FAIL is sticky.
REQ-031 SHALL load the o_first_err_* registers only on the IDLE/PASS -> FAIL transition; with several channels mismatching in that beat, the lowest channel index SHALL be captured.
REQ-032 SHALL make i_clear return the state machine to IDLE and zero all counters and o_first_err_* on the next edge; i_clear SHALL win over a simultaneous check.
REQ-033 SHALL leave the delay line unaffected by i_clear; beats in flight SHALL still be checked after the clear.

Reset
REQ-034 SHALL on resetn low, immediately and asynchronously, set o_status=0, all counters=0, o_first_err_*=0, and clear every delay-line valid tag.
REQ-035 SHALL ensure no check occurs for beats accepted before reset deassertion.

Verification
REQ-036 SHALL verify, with NUM_CH=2, DOT_SIZE=2, widths 8/8/20, LATENCY=3, SIGN_MODE=0: both channels get feature {0x03,0x04} and filter {0x05,0x82}; result 7 at t+3 -> o_status=1, o_check_count=1, o_err_count=0 at t+4.
REQ-037 SHALL verify the same beat with ch1 result 8 -> o_status=2, o_err_count=1, o_first_err_ch=1, exp=7, act=8.
REQ-038 SHALL verify CNT_WIDTH=4 with 20 consecutive single-channel mismatches -> o_err_count=15 held.
REQ-039 SHALL verify i_clear asserted in the same cycle as a mismatch check -> o_status=0, o_err_count=0 next cycle; a later in-flight clean beat -> PASS.
REQ-040 SHALL verify a valid beat at t with resetn pulsed low at t+1 -> outputs zero and no check at t+3/t+4.
REQ-041 SHALL verify SIGN_MODE=1 with feature {0xFF,0x00} and filter {0x02,0x00} -> expected 0xFFFFE; result 0xFFFFE -> PASS.
